// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: steps the digit select, drives the
// active-low anodes with a blanking gap per slot, and double-buffers the display value.
// All outputs registered; anodes are decoded from next-state so they align with cnt/sel.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        blank_lz,
  output logic [31:0] disp_data,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  // Slot phase decoded from the counter
  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_DRIVE = 1'b1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    an_q, an_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          fd_q, fd_d;
  logic [0:0]    phase_d;
  logic          slot_end;
  logic          frame_end;

  // A digit above the ones place is dark when it and every more significant digit are zero.
  function automatic logic lz_blank(input logic [31:0] val, input logic [2:0] idx,
                                    input logic en);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(idx)) upper_zero = upper_zero & (val[4*k +: 4] == 4'h0);
    end
    return en && (idx != 3'd0) && upper_zero;
  endfunction

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (sel_q == 3'd7);

  // Next-state: slot/digit stepping, buffer swap at the frame wrap, and anode decode
  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    sel_d    = slot_end ? sel_q + 3'd1 : sel_q;
    shadow_d = load ? data_in : shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    fd_d     = frame_end;
    if (frame_end) begin
      // A load landing on the wrap edge is newer than anything in the shadow.
      if (load)        disp_d = data_in;
      else if (pend_q) disp_d = shadow_q;
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end
    phase_d = (cnt_d < BLANK_END) ? PH_BLANK : PH_DRIVE;
    an_d    = 8'hFF;
    if (phase_d == PH_DRIVE && !lz_blank(disp_d, sel_d, blank_lz)) begin
      an_d = ~(8'd1 << sel_d);
    end
  end

  // State registers; reset aborts the scan and drops any pending value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sel_q    <= 3'd0;
      an_q     <= 8'hFF;
      disp_q   <= 32'd0;
      shadow_q <= 32'd0;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
    end
  end

  assign disp_data  = disp_q;
  assign sel        = sel_q;
  assign an         = an_q;
  assign pending    = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: main instance (CLK_DIV=8, BLANK_CYC=2) against a time-based model,
// plus a ghost-gap instance (CLK_DIV=4, BLANK_CYC=1).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seg_scan_ctrl;

  localparam int CD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data_in;
  logic        blank_lz;
  logic [31:0] disp_data;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic        pending;
  logic        frame_done;

  logic        load_b;
  logic [31:0] data_in_b;
  logic        blank_lz_b;
  logic [31:0] disp_data_b;
  logic [2:0]  sel_b;
  logic [7:0]  an_b;
  logic        pending_b;
  logic        frame_done_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut_a (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .blank_lz(blank_lz),
    .disp_data(disp_data), .sel(sel), .an(an), .pending(pending), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .data_in(data_in_b), .blank_lz(blank_lz_b),
    .disp_data(disp_data_b), .sel(sel_b), .an(an_b), .pending(pending_b),
    .frame_done(frame_done_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model: time since reset drives the scan ----------------
  int          m_t = 0;
  logic [31:0] m_disp = 0;
  logic [31:0] m_shadow = 0;
  logic        m_pend = 0;
  logic        m_blz = 0;
  bit          m_valid = 0;

  function automatic logic [7:0] exp_an(input int t, input logic [31:0] v, input logic blz);
    int c;
    int s;
    c = t % CD;
    s = (t / CD) % 8;
    if (c < BC) return 8'hFF;
    if (blz && s != 0 && (v >> (4 * s)) == 32'd0) return 8'hFF;
    return ~(8'h01 << s);
  endfunction

  always @(posedge clk) begin
    m_valid = 1;
    if (rst) begin
      m_t = 0; m_disp = 0; m_shadow = 0; m_pend = 0; m_blz = blank_lz;
    end else begin
      if ((m_t % (8 * CD)) == 8 * CD - 1) begin
        if (load) m_disp = data_in;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end
      if (load) m_shadow = data_in;
      m_blz = blank_lz;
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_sel",  {29'd0, sel}, 32'((m_t / CD) % 8));
      chk("m_an",   {24'd0, an}, {24'd0, exp_an(m_t, m_disp, m_blz)});
      chk("m_disp", disp_data, m_disp);
      chk("m_pend", {31'd0, pending}, {31'd0, m_pend});
      chk("m_fd",   {31'd0, frame_done}, (m_t > 0 && (m_t % (8 * CD)) == 0) ? 32'd1 : 32'd0);
    end
  end

  // ---------------- ghost-gap watcher on the short-slot instance ----------------
  bit       b_rst_seen = 0;
  bit       b_started = 0;
  int       ff_run = 0;
  logic [7:0] prev_b = 8'hFF;
  logic [7:0] onehot_b;

  always @(posedge clk) begin
    b_rst_seen = rst;
    b_started  = 1;
  end

  always @(negedge clk) begin
    if (b_started) begin
      if (b_rst_seen) begin
        chk("ghost_rst_an", {24'd0, an_b}, 32'hFF);
        ff_run = 1;
      end else if (an_b == 8'hFF) begin
        ff_run++;
      end else begin
        onehot_b = ~(8'h01 << sel_b);
        chk("ghost_onehot", {24'd0, an_b}, {24'd0, onehot_b});
        if (prev_b != 8'hFF) chk("ghost_same_digit", {24'd0, an_b}, {24'd0, prev_b});
        else chk("ghost_gap_len", 32'(ff_run), 32'd1);
        ff_run = 0;
      end
      prev_b = an_b;
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 32'd0; blank_lz = 1'b0;
    load_b = 1'b0; data_in_b = 32'd0; blank_lz_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    chk("rst_sel", {29'd0, sel}, 32'd0);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_disp", disp_data, 32'd0);
    chk("rst_pend", {31'd0, pending}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    goto(2);  chk("d0_drive", {24'd0, an}, 32'hFE);
    goto(7);  chk("d0_last", {24'd0, an}, 32'hFE);
    goto(8);  chk("d1_sel", {29'd0, sel}, 32'd1);
              chk("d1_blank", {24'd0, an}, 32'hFF);
    goto(10); chk("d1_drive", {24'd0, an}, 32'hFD);
              load = 1'b1; data_in = 32'h1234_5678;
    goto(11); load = 1'b0;
              chk("defer_pend", {31'd0, pending}, 32'd1);
    goto(63); chk("defer_hold", disp_data, 32'd0);
              chk("sel7", {29'd0, sel}, 32'd7);
    goto(64); chk("defer_show", disp_data, 32'h1234_5678);
              chk("defer_pend0", {31'd0, pending}, 32'd0);
              chk("fd_64", {31'd0, frame_done}, 32'd1);
              chk("wrap_sel", {29'd0, sel}, 32'd0);
    goto(65); chk("fd_65", {31'd0, frame_done}, 32'd0);
    goto(84); load = 1'b1; data_in = 32'hAAAA_0001;
    goto(85); load = 1'b0;
    goto(100); blank_lz = 1'b1;
    goto(127); load = 1'b1; data_in = 32'h0000_0042;
    goto(128); load = 1'b0;
              chk("coinc_disp", disp_data, 32'h0000_0042);
              chk("coinc_pend", {31'd0, pending}, 32'd0);
    goto(130); chk("lz_d0", {24'd0, an}, 32'hFE);
    goto(138); chk("lz_d1", {24'd0, an}, 32'hFD);
    goto(146); chk("lz_d2", {24'd0, an}, 32'hFF);
    goto(150); load = 1'b1; data_in = 32'd0;
    goto(151); load = 1'b0;
    goto(186); chk("lz_d7", {24'd0, an}, 32'hFF);
    goto(192); chk("zero_disp", disp_data, 32'd0);
    goto(194); chk("zero_d0", {24'd0, an}, 32'hFE);
    goto(202); chk("zero_d1", {24'd0, an}, 32'hFF);
    goto(205); blank_lz = 1'b0;
    goto(206); chk("nolz_d1", {24'd0, an}, 32'hFD);
    goto(210); chk("nolz_d2", {24'd0, an}, 32'hFB);
    goto(230); load = 1'b1; data_in = 32'h0000_0009;
    goto(231); load = 1'b0;
    goto(236); chk("mid_sel", {29'd0, sel}, 32'd5);
               chk("mid_pend", {31'd0, pending}, 32'd1);
               rst = 1'b1;
    goto(237); rst = 1'b0;
    cyc = 0;
    chk("mrst_sel", {29'd0, sel}, 32'd0);
    chk("mrst_an", {24'd0, an}, 32'hFF);
    chk("mrst_disp", disp_data, 32'd0);
    chk("mrst_pend", {31'd0, pending}, 32'd0);
    goto(2);  chk("mrst_d0", {24'd0, an}, 32'hFE);
    goto(64); chk("mrst_fd", {31'd0, frame_done}, 32'd1);
              chk("mrst_drop", disp_data, 32'd0);
    goto(70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
